// File: rtl/traffic_pkg.sv
// Shared state encodings and lamp patterns for the two-road intersection controller.
// Lamp bus layout is {A[2:0],B[2:0]}, each group {green,yellow,red}.
package traffic_pkg;

   typedef enum logic [2:0] {
      S_B_GO  = 3'd0,
      S_B_YEL = 3'd1,
      S_RED1  = 3'd2,
      S_A_GO  = 3'd3,
      S_A_YEL = 3'd4,
      S_RED2  = 3'd5,
      S_WALK  = 3'd6,
      S_FLASH = 3'd7
   } state_e;

   localparam logic [5:0] LT_B_GO     = 6'b001_100;
   localparam logic [5:0] LT_B_YEL    = 6'b001_010;
   localparam logic [5:0] LT_ALLRED   = 6'b001_001;
   localparam logic [5:0] LT_A_GO     = 6'b100_001;
   localparam logic [5:0] LT_A_YEL    = 6'b010_001;
   localparam logic [5:0] LT_FLASH_ON = 6'b010_001;
   localparam logic [5:0] LT_DARK     = 6'b000_000;

   function automatic logic [5:0] lamp_of(input state_e s, input logic flash_on);
      logic [5:0] lt;
      case (s)
         S_B_GO:  lt = LT_B_GO;
         S_B_YEL: lt = LT_B_YEL;
         S_A_GO:  lt = LT_A_GO;
         S_A_YEL: lt = LT_A_YEL;
         S_FLASH: lt = flash_on ? LT_FLASH_ON : LT_DARK;
         default: lt = LT_ALLRED;
      endcase
      return lt;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request inputs and lamp outputs of the intersection controller.
interface traffic_light_ctrl_if;
   logic       rush;
   logic       ped_req;
   logic       night;
   logic [5:0] light;
   logic       walk;
   logic [2:0] phase;

   modport master (output rush, ped_req, night, input light, walk, phase);
   modport slave  (input rush, ped_req, night, output light, walk, phase);
endinterface

// File: rtl/phase_timer.sv
// Cycle counter that restarts from 0 on load and flags the last cycle of a duration.
module phase_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] dur,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign done = (cnt_q == dur - CNT_W'(1));

   always_comb begin
      cnt_d = load ? '0 : cnt_q + CNT_W'(1);
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with rush-hour green, latched pedestrian walk
// phase and night flashing mode entered and left only via an all-red phase.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int          CNT_W       = 32,
   parameter int unsigned B_GREEN_CYC = 100000000,
   parameter int unsigned A_GREEN_CYC = 100000000,
   parameter int unsigned RUSH_CYC    = 200000000,
   parameter int unsigned YELLOW_CYC  = 100000000,
   parameter int unsigned ALLRED_CYC  = 100000000,
   parameter int unsigned WALK_CYC    = 100000000,
   parameter int unsigned FLASH_CYC   = 50000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   traffic_light_ctrl_if.slave    bus
);

   state_e     state_q, state_d;
   logic       rush_q, rush_d;
   logic       ped_pend_q, ped_pend_d;
   logic       flash_on_q, flash_on_d;
   logic [5:0] light_q, light_d;
   logic       walk_q, walk_d;

   logic [CNT_W-1:0] phase_dur;
   logic             phase_done, flash_done;

   always_comb begin
      phase_dur = CNT_W'(ALLRED_CYC);
      case (state_q)
         S_B_GO:          phase_dur = CNT_W'(B_GREEN_CYC);
         S_A_GO:          phase_dur = rush_q ? CNT_W'(RUSH_CYC) : CNT_W'(A_GREEN_CYC);
         S_B_YEL, S_A_YEL: phase_dur = CNT_W'(YELLOW_CYC);
         S_WALK:          phase_dur = CNT_W'(WALK_CYC);
         default:         phase_dur = CNT_W'(ALLRED_CYC);
      endcase
   end

   // The phase counter idles at 0 during flashing so RED2 starts fresh on exit.
   phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (phase_done || (state_q == S_FLASH)),
      .dur   (phase_dur),
      .done  (phase_done)
   );

   phase_timer #(.CNT_W(CNT_W)) u_flash_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (flash_done || (state_q != S_FLASH)),
      .dur   (CNT_W'(FLASH_CYC)),
      .done  (flash_done)
   );

   // NOTE: every variable gets a default first so no path through the block infers a latch.
   always_comb begin
      state_d    = state_q;
      rush_d     = rush_q;
      ped_pend_d = ped_pend_q;
      flash_on_d = flash_on_q;

      if (bus.ped_req && (state_q != S_WALK) && (state_q != S_FLASH)) ped_pend_d = 1'b1;

      case (state_q)
         S_B_GO:  if (phase_done) state_d = S_B_YEL;
         S_B_YEL: if (phase_done) state_d = S_RED1;
         S_RED1: begin
            if (phase_done) begin
               if (bus.night) state_d = S_FLASH;
               else begin
                  state_d = S_A_GO;
                  rush_d  = bus.rush;
               end
            end
         end
         S_A_GO:  if (phase_done) state_d = S_A_YEL;
         S_A_YEL: if (phase_done) state_d = S_RED2;
         S_RED2: begin
            if (phase_done) begin
               if (bus.night) state_d = S_FLASH;
               else if (ped_pend_q) begin
                  state_d    = S_WALK;
                  ped_pend_d = 1'b0;
               end else state_d = S_B_GO;
            end
         end
         S_WALK:  if (phase_done) state_d = S_B_GO;
         S_FLASH: begin
            if (flash_done) begin
               if (!bus.night) state_d = S_RED2;
               else            flash_on_d = ~flash_on_q;
            end
         end
         default: state_d = S_B_GO;
      endcase

      if ((state_d == S_FLASH) && (state_q != S_FLASH)) begin
         ped_pend_d = 1'b0;
         flash_on_d = 1'b1;
      end

      // Lamps decode the next state so they change on the same edge as the state.
      light_d = lamp_of(state_d, flash_on_d);
      walk_d  = (state_d == S_WALK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_B_GO;
         rush_q     <= 1'b0;
         ped_pend_q <= 1'b0;
         flash_on_q <= 1'b0;
         light_q    <= LT_B_GO;
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rush_q     <= rush_d;
         ped_pend_q <= ped_pend_d;
         flash_on_q <= flash_on_d;
         light_q    <= light_d;
         walk_q     <= walk_d;
      end
   end

   assign bus.light = light_q;
   assign bus.walk  = walk_q;
   assign bus.phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: a cycle model pushes expected lamps per edge, a negedge monitor compares.
module tb_traffic_light_ctrl;

   localparam int BG = 4, AG = 4, RU = 8, YE = 2, AR = 1, WK = 3, FL = 2;

   localparam logic [2:0] B_GO = 3'd0, B_YEL = 3'd1, RED1 = 3'd2, A_GO = 3'd3;
   localparam logic [2:0] A_YEL = 3'd4, RED2 = 3'd5, WALK = 3'd6, FLASH = 3'd7;

   typedef struct packed {
      logic [2:0] ph;
      logic [5:0] lt;
      logic       wk;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   traffic_light_ctrl_if tif ();

   traffic_light_ctrl #(
      .CNT_W(8), .B_GREEN_CYC(BG), .A_GREEN_CYC(AG), .RUSH_CYC(RU),
      .YELLOW_CYC(YE), .ALLRED_CYC(AR), .WALK_CYC(WK), .FLASH_CYC(FL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (tif.slave)
   );

   always #5 clk = ~clk;

   int   n_total = 0;
   int   n_bad   = 0;
   int   n_mon   = 0;
   exp_t sb_q[$];

   logic [2:0] m_state;
   int         m_left, m_flash_left;
   logic       m_rush, m_pend, m_flash_on;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] exp_light(input logic [2:0] s, input logic fon);
      case (s)
         B_GO:    return 6'b001100;
         B_YEL:   return 6'b001010;
         A_GO:    return 6'b100001;
         A_YEL:   return 6'b010001;
         FLASH:   return fon ? 6'b010001 : 6'b000000;
         default: return 6'b001001;
      endcase
   endfunction

   function automatic int dur_of(input logic [2:0] s, input logic rsh);
      case (s)
         B_GO:         return BG;
         A_GO:         return rsh ? RU : AG;
         B_YEL, A_YEL: return YE;
         WALK:         return WK;
         default:      return AR;
      endcase
   endfunction

   task automatic model_reset();
      m_state = B_GO; m_left = BG; m_pend = 1'b0; m_rush = 1'b0;
      m_flash_on = 1'b1; m_flash_left = FL;
   endtask

   task automatic model_step(input logic r, input logic p, input logic n);
      logic [2:0] nxt;
      logic       ped_ok;
      nxt    = m_state;
      ped_ok = p && (m_state != WALK) && (m_state != FLASH);
      if (m_state == FLASH) begin
         if (m_flash_left == 1) begin
            if (!n) begin nxt = RED2; m_left = AR; end
            else begin m_flash_on = !m_flash_on; m_flash_left = FL; end
         end else m_flash_left--;
      end else if (m_left == 1) begin
         case (m_state)
            B_GO:  nxt = B_YEL;
            B_YEL: nxt = RED1;
            RED1:  if (n) nxt = FLASH; else begin nxt = A_GO; m_rush = r; end
            A_GO:  nxt = A_YEL;
            A_YEL: nxt = RED2;
            RED2:  nxt = n ? FLASH : (m_pend ? WALK : B_GO);
            default: nxt = B_GO;
         endcase
         m_left = dur_of(nxt, m_rush);
      end else m_left--;
      if ((nxt == FLASH) && (m_state != FLASH)) begin
         m_pend = 1'b0; m_flash_on = 1'b1; m_flash_left = FL;
      end else if ((nxt == WALK) && (m_state == RED2)) m_pend = 1'b0;
      else m_pend = m_pend | ped_ok;
      m_state = nxt;
   endtask

   // Called at negedge+1; drives inputs, predicts the post-edge outputs, advances one cycle.
   task automatic tick(input logic r, input logic p, input logic n);
      exp_t e;
      tif.rush = r; tif.ped_req = p; tif.night = n;
      model_step(r, p, n);
      e.ph = m_state;
      e.lt = exp_light(m_state, m_flash_on);
      e.wk = (m_state == WALK);
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic run_until(input logic [2:0] s);
      for (int i = 0; i < 40 && m_state != s; i++) tick(1'b0, 1'b0, 1'b0);
      check("reach_state", {29'd0, m_state}, {29'd0, s});
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_mon++;
         check($sformatf("phase@%0d", n_mon), {29'd0, tif.phase}, {29'd0, e.ph});
         check($sformatf("light@%0d", n_mon), {26'd0, tif.light}, {26'd0, e.lt});
         check($sformatf("walk@%0d", n_mon),  {31'd0, tif.walk},  {31'd0, e.wk});
      end
   end

   initial begin
      #90000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      tif.rush = 1'b0; tif.ped_req = 1'b0; tif.night = 1'b0;
      model_reset();
      #12;
      check("rst_light", {26'd0, tif.light}, 32'h0C);
      check("rst_walk",  {31'd0, tif.walk},  32'h0);
      check("rst_phase", {29'd0, tif.phase}, 32'h0);
      @(negedge clk); #1;
      rst_n = 1'b1;

      // Normal cycle, two full rounds.
      repeat (28) tick(1'b0, 1'b0, 1'b0);

      // Rush held across the RED1->A_GO edge, then rush only while in A_GO.
      for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) tick(m_state == A_GO, 1'b0, 1'b0);

      // Pedestrian pulse in B_GO; presses during WALK must be dropped.
      run_until(B_GO);
      tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) tick(1'b0, m_state == WALK, 1'b0);

      // Night requested during A_GO, then released mid-flash.
      run_until(A_GO);
      repeat (12) tick(1'b0, 1'b0, 1'b1);
      repeat (12) tick(1'b0, 1'b0, 1'b0);

      // Night wins over a pending walk; the pending request is lost.
      run_until(B_GO);
      tick(1'b0, 1'b1, 1'b0);
      run_until(A_YEL);
      repeat (10) tick(1'b0, 1'b0, 1'b1);
      repeat (25) tick(1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges in the middle of A_GO.
      run_until(A_GO);
      tick(1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_light", {26'd0, tif.light}, 32'h0C);
      check("arst_walk",  {31'd0, tif.walk},  32'h0);
      check("arst_phase", {29'd0, tif.phase}, 32'h0);
      @(negedge clk); #1;
      model_reset();
      rst_n = 1'b1;
      repeat (20) tick(1'b0, 1'b0, 1'b0);

      check("sb_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
